// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, cell-grid geometry and colour encoding
// for the VGA output stage.
package vga_timing_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int CELL_SHIFT = 3;
  localparam int ADDR_W     = 13;
  localparam int CNT_W      = 10;
  localparam int GRID_W     = 80;
  localparam int GRID_H     = 60;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_t;

endpackage

// File: rtl/vga_sync_counter.sv
// Pixel enable, raster counters and sync/visible decode. frame_start is a
// registered one-Clock pulse on the tick that leaves pixel (0,0).
module vga_sync_counter
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_VISIBLE,
  parameter int H_FP     = H_FRONT,
  parameter int H_SW     = H_SYNC,
  parameter int H_BP     = H_BACK,
  parameter int V_ACTIVE = V_VISIBLE,
  parameter int V_FP     = V_FRONT,
  parameter int V_SW     = V_SYNC,
  parameter int V_BP     = V_BACK
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             tick,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             line_end,
  output logic             frame_end,
  output logic             visible,
  output logic             hsync_n,
  output logic             vsync_n,
  output logic             frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SW + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SW + V_BP;

  logic phase;

  assign tick      = phase;
  assign line_end  = (hcount == CNT_W'(H_TOTAL - 1));
  assign frame_end = line_end && (vcount == CNT_W'(V_TOTAL - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase       <= 1'b0;
      hcount      <= '0;
      vcount      <= '0;
      frame_start <= 1'b0;
    end else begin
      phase       <= ~phase;
      frame_start <= phase && (hcount == '0) && (vcount == '0);
      if (phase) begin
        if (line_end) begin
          hcount <= '0;
          vcount <= frame_end ? '0 : vcount + 1'b1;
        end else begin
          hcount <= hcount + 1'b1;
        end
      end
    end
  end

  assign visible = (hcount < CNT_W'(H_ACTIVE)) && (vcount < CNT_W'(V_ACTIVE));
  assign hsync_n = !((hcount >= CNT_W'(H_ACTIVE + H_FP)) &&
                     (hcount <  CNT_W'(H_ACTIVE + H_FP + H_SW)));
  assign vsync_n = !((vcount >= CNT_W'(V_ACTIVE + V_FP)) &&
                     (vcount <  CNT_W'(V_ACTIVE + V_FP + V_SW)));

endmodule

// File: rtl/vga_frame_scanner.sv
// VGA output stage: incremental cell address generation and a two-tick
// pipeline (address/decode stage, then pin stage) driving the connector.
module vga_frame_scanner
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_VISIBLE,
  parameter int H_FP     = H_FRONT,
  parameter int H_SW     = H_SYNC,
  parameter int H_BP     = H_BACK,
  parameter int V_ACTIVE = V_VISIBLE,
  parameter int V_FP     = V_FRONT,
  parameter int V_SW     = V_SYNC,
  parameter int V_BP     = V_BACK
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [2:0]        iColor,
  output logic [ADDR_W-1:0] oAddr,
  output logic              oFrameStart,
  output logic              VGA_RED,
  output logic              VGA_GREEN,
  output logic              VGA_BLUE,
  output logic              VGA_HSYNC,
  output logic              VGA_VSYNC
);

  localparam int ROW_STRIDE = H_ACTIVE >> CELL_SHIFT;

  logic             tick;
  logic             line_end;
  logic             frame_end;
  logic             visible;
  logic             hsync_n;
  logic             vsync_n;
  logic [CNT_W-1:0] hcount;
  logic [CNT_W-1:0] vcount;
  logic [ADDR_W-1:0] row_base;
  logic             row_step;
  logic             vis_a;
  logic             hs_a;
  logic             vs_a;
  rgb_t             pix_b;

  vga_sync_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SW(H_SW), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SW(V_SW), .V_BP(V_BP)
  ) u_sync (
    .clk         (Clock),
    .rst_n       (Reset),
    .tick        (tick),
    .hcount      (hcount),
    .vcount      (vcount),
    .line_end    (line_end),
    .frame_end   (frame_end),
    .visible     (visible),
    .hsync_n     (hsync_n),
    .vsync_n     (vsync_n),
    .frame_start (oFrameStart)
  );

  // Step to the next cell row when the last line of a cell row ends.
  assign row_step = line_end && (&vcount[CELL_SHIFT-1:0]) &&
                    (vcount < CNT_W'(V_ACTIVE - 1));

  // Sync stage registers reset inactive so no sync pulse leaks out of reset.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      row_base  <= '0;
      oAddr     <= '0;
      vis_a     <= 1'b0;
      hs_a      <= 1'b1;
      vs_a      <= 1'b1;
      pix_b     <= '0;
      VGA_HSYNC <= 1'b1;
      VGA_VSYNC <= 1'b1;
    end else if (tick) begin
      if (frame_end) begin
        row_base <= '0;
      end else if (row_step) begin
        row_base <= row_base + ADDR_W'(ROW_STRIDE);
      end
      if (visible) begin
        oAddr <= row_base + ADDR_W'(hcount >> CELL_SHIFT);
      end
      vis_a     <= visible;
      hs_a      <= hsync_n;
      vs_a      <= vsync_n;
      pix_b     <= vis_a ? rgb_t'(iColor) : '0;
      VGA_HSYNC <= hs_a;
      VGA_VSYNC <= vs_a;
    end
  end

  assign VGA_RED   = pix_b.r;
  assign VGA_GREEN = pix_b.g;
  assign VGA_BLUE  = pix_b.b;

endmodule
